// File: rtl/video_pkg.sv
// Shared constants for the video_processing chain.
// Holds the Q8 BT.601 inverse-conversion coefficients, the chroma offset,
// the rounding term and the pipeline depth of the YCbCr->RGB stage.
package video_pkg;

  // Q8 coefficients: 1.402, 0.344, 0.714 and 1.772 scaled by 256.
  localparam logic signed [9:0] K_CR_R = 10'sd359;
  localparam logic signed [9:0] K_CB_G = 10'sd88;
  localparam logic signed [9:0] K_CR_G = 10'sd183;
  localparam logic signed [9:0] K_CB_B = 10'sd454;

  // Chroma is stored with a +128 bias; Q8 half-LSB for round-to-nearest.
  localparam logic [7:0]         CHROMA_OFS = 8'd128;
  localparam logic signed [17:0] RND_Q8     = 18'sd128;

  // Clock cycles from input to output of image_ycbcr444_rgb888.
  // Parent modules use it to delay side-band signals to match.
  localparam int YCC2RGB_LAT = 3;

  // Remove the chroma bias: 0..255 becomes -128..127.
  function automatic logic signed [8:0] chroma_offset(input logic [7:0] c);
    return $signed({1'b0, c}) - $signed({1'b0, CHROMA_OFS});
  endfunction

endpackage

// File: rtl/sat_shift_u8.sv
// Final conversion stage for one colour channel.
// Drops the Q8 fraction with an arithmetic (floor) shift, clamps the
// result to 0..255 and registers the 8-bit channel value.
module sat_shift_u8 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [17:0] din,
  output logic [7:0]         dout
);

  // After the shift the value lies in -227..480, so 10 signed bits suffice.
  logic signed [9:0] shifted;

  assign shifted = 10'(din >>> 8);

  // Clamp negatives to black and overshoots to full scale, then register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'd0;
    end else if (shifted < 10'sd0) begin
      dout <= 8'd0;
    end else if (shifted > 10'sd255) begin
      dout <= 8'd255;
    end else begin
      dout <= shifted[7:0];
    end
  end

endmodule

// File: rtl/image_ycbcr444_rgb888.sv
// Full-range BT.601 YCbCr 4:4:4 to RGB888 converter, three-stage pipeline.
// Stage 1 registers the luma term and the chroma products, stage 2 the
// rounded sums and stage 3 (sat_shift_u8) the clamped 8-bit channels.
// The frame qualifiers are delayed by the same three clocks, and the RGB
// outputs are held at zero whenever the delayed href is low.
module image_ycbcr444_rgb888
  import video_pkg::*;
#(
  parameter logic [15:0] IMG_HDISP = 16'd640,
  parameter logic [15:0] IMG_VDISP = 16'd480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  input  logic [7:0] per_img_Cb,
  input  logic [7:0] per_img_Cr,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_red,
  output logic [7:0] post_img_green,
  output logic [7:0] post_img_blue
);

  // The frame size does not affect the arithmetic; it is only kept so every
  // block in the chain has the same parameter list. A zero size is a wiring
  // mistake in the parent and is rejected at elaboration.
  if (IMG_HDISP == 16'd0 || IMG_VDISP == 16'd0) begin : g_bad_size
    $error("image_ycbcr444_rgb888: IMG_HDISP and IMG_VDISP must be non-zero");
  end

  // Stage 1 signals.
  logic signed [8:0]  cb_ofs;
  logic signed [8:0]  cr_ofs;
  logic signed [16:0] cb_ext;
  logic signed [16:0] cr_ext;
  logic [16:0]        y_256_d;
  logic signed [16:0] cr_r_d;
  logic signed [16:0] cb_g_d;
  logic signed [16:0] cr_g_d;
  logic signed [16:0] cb_b_d;
  logic [16:0]        y_256_q;
  logic signed [16:0] cr_r_q;
  logic signed [16:0] cb_g_q;
  logic signed [16:0] cr_g_q;
  logic signed [16:0] cb_b_q;

  // Stage 2 signals.
  logic signed [17:0] y_term;
  logic signed [17:0] sum_r_d;
  logic signed [17:0] sum_g_d;
  logic signed [17:0] sum_b_d;
  logic signed [17:0] sum_r_q;
  logic signed [17:0] sum_g_q;
  logic signed [17:0] sum_b_q;

  // Stage 3 outputs and qualifier delay lines.
  logic [7:0]             red_q;
  logic [7:0]             green_q;
  logic [7:0]             blue_q;
  logic [YCC2RGB_LAT-1:0] vsync_dly;
  logic [YCC2RGB_LAT-1:0] href_dly;
  logic [YCC2RGB_LAT-1:0] clken_dly;

  // Stage 1 combinational: unbias chroma, scale luma by 256 and form the
  // four chroma products; every product fits in 17 signed bits.
  always_comb begin
    cb_ofs  = chroma_offset(per_img_Cb);
    cr_ofs  = chroma_offset(per_img_Cr);
    cb_ext  = 17'(cb_ofs);
    cr_ext  = 17'(cr_ofs);
    y_256_d = {1'b0, per_img_Y, 8'd0};
    cr_r_d  = cr_ext * 17'(K_CR_R);
    cb_g_d  = cb_ext * 17'(K_CB_G);
    cr_g_d  = cr_ext * 17'(K_CR_G);
    cb_b_d  = cb_ext * 17'(K_CB_B);
  end

  // Stage 1 register; runs every clock, blanking data passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_256_q <= '0;
      cr_r_q  <= '0;
      cb_g_q  <= '0;
      cr_g_q  <= '0;
      cb_b_q  <= '0;
    end else begin
      y_256_q <= y_256_d;
      cr_r_q  <= cr_r_d;
      cb_g_q  <= cb_g_d;
      cr_g_q  <= cr_g_d;
      cb_b_q  <= cb_b_d;
    end
  end

  // Stage 2 combinational: per-channel sums with the half-LSB rounding term.
  // The worst case spans -58112..123066, inside 18 signed bits.
  always_comb begin
    y_term  = $signed({1'b0, y_256_q});
    sum_r_d = y_term + 18'(cr_r_q) + RND_Q8;
    sum_g_d = y_term - 18'(cb_g_q) - 18'(cr_g_q) + RND_Q8;
    sum_b_d = y_term + 18'(cb_b_q) + RND_Q8;
  end

  // Stage 2 register holding the three Q8 sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
    end else begin
      sum_r_q <= sum_r_d;
      sum_g_q <= sum_g_d;
      sum_b_q <= sum_b_d;
    end
  end

  // Stage 3: shift, clamp and register each channel independently.
  sat_shift_u8 u_sat_red (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sum_r_q),
    .dout  (red_q)
  );

  sat_shift_u8 u_sat_green (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sum_g_q),
    .dout  (green_q)
  );

  sat_shift_u8 u_sat_blue (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sum_b_q),
    .dout  (blue_q)
  );

  // Qualifier shift registers, one tap per pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_dly <= '0;
      href_dly  <= '0;
      clken_dly <= '0;
    end else begin
      vsync_dly <= {vsync_dly[YCC2RGB_LAT-2:0], per_frame_vsync};
      href_dly  <= {href_dly[YCC2RGB_LAT-2:0], per_frame_href};
      clken_dly <= {clken_dly[YCC2RGB_LAT-2:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vsync_dly[YCC2RGB_LAT-1];
  assign post_frame_href  = href_dly[YCC2RGB_LAT-1];
  assign post_frame_clken = clken_dly[YCC2RGB_LAT-1];

  // Outside the active line the pipeline still carries blanking data, so
  // the colour outputs are masked with the delayed href.
  assign post_img_red   = post_frame_href ? red_q   : 8'd0;
  assign post_img_green = post_frame_href ? green_q : 8'd0;
  assign post_img_blue  = post_frame_href ? blue_q  : 8'd0;

endmodule

// File: tb/tb_image_ycbcr444_rgb888.sv
// Bench for image_ycbcr444_rgb888.
// A driver applies directed YCbCr vectors and pushes the hand-computed RGB
// and qualifier values, tagged with the cycle they are due, into a queue;
// a monitor on the falling edge pops and compares them.
module tb_image_ycbcr444_rgb888;

  localparam int LAT = 3;
  localparam int NVEC = 11;

  typedef struct {
    int         due;
    string      name;
    logic       vsync;
    logic       href;
    logic       clken;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_Y;
  logic [7:0] per_img_Cb;
  logic [7:0] per_img_Cr;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_red;
  logic [7:0] post_img_green;
  logic [7:0] post_img_blue;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  // Directed vectors: Y, Cb, Cr and the hand-computed R, G, B.
  logic [7:0] vec_y  [NVEC] = '{8'd128, 8'd0,   8'd255, 8'd0,   8'd255, 8'd100,
                                8'd50,  8'd16,  8'd76,  8'd200, 8'd128};
  logic [7:0] vec_cb [NVEC] = '{8'd128, 8'd128, 8'd255, 8'd0,   8'd128, 8'd90,
                                8'd200, 8'd128, 8'd85,  8'd128, 8'd128};
  logic [7:0] vec_cr [NVEC] = '{8'd128, 8'd255, 8'd255, 8'd0,   8'd128, 8'd200,
                                8'd60,  8'd128, 8'd255, 8'd128, 8'd128};
  logic [7:0] vec_r  [NVEC] = '{8'd128, 8'd178, 8'd255, 8'd0,   8'd255, 8'd201,
                                8'd0,   8'd16,  8'd254, 8'd200, 8'd128};
  logic [7:0] vec_g  [NVEC] = '{8'd128, 8'd0,   8'd121, 8'd136, 8'd255, 8'd62,
                                8'd74,  8'd16,  8'd0,   8'd200, 8'd128};
  logic [7:0] vec_b  [NVEC] = '{8'd128, 8'd0,   8'd255, 8'd0,   8'd255, 8'd33,
                                8'd178, 8'd16,  8'd0,   8'd200, 8'd128};

  image_ycbcr444_rgb888 #(
    .IMG_HDISP (16'd640),
    .IMG_VDISP (16'd480)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_Y        (per_img_Y),
    .per_img_Cb       (per_img_Cb),
    .per_img_Cr       (per_img_Cr),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_red     (post_img_red),
    .post_img_green   (post_img_green),
    .post_img_blue    (post_img_blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare the whole output tuple against one expected entry.
  task automatic checkOutput(input exp_t e);
    n_checks++;
    if (post_frame_vsync !== e.vsync || post_frame_href !== e.href ||
        post_frame_clken !== e.clken || post_img_red !== e.red ||
        post_img_green !== e.green || post_img_blue !== e.blue) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d got v/h/c=%b%b%b rgb=%0d,%0d,%0d want v/h/c=%b%b%b rgb=%0d,%0d,%0d",
               e.name, cyc, post_frame_vsync, post_frame_href, post_frame_clken,
               post_img_red, post_img_green, post_img_blue,
               e.vsync, e.href, e.clken, e.red, e.green, e.blue);
    end
  endtask

  function automatic exp_t zero_exp(input int due, input string name);
    exp_t e;
    e.due = due; e.name = name;
    e.vsync = 1'b0; e.href = 1'b0; e.clken = 1'b0;
    e.red = 8'd0; e.green = 8'd0; e.blue = 8'd0;
    return e;
  endfunction

  // Drive inputs for one cycle and queue the response due LAT clocks later.
  task automatic driveInputs(input string name, input int idx,
                             input logic vs, input logic hr, input logic ce);
    exp_t e;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ce;
    per_img_Y       = vec_y[idx];
    per_img_Cb      = vec_cb[idx];
    per_img_Cr      = vec_cr[idx];
    e = zero_exp(cyc + LAT, name);
    e.vsync = vs;
    e.href  = hr;
    e.clken = ce;
    if (hr) begin
      e.red   = vec_r[idx];
      e.green = vec_g[idx];
      e.blue  = vec_b[idx];
    end
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input string name, input int idx,
                               input logic vs, input logic hr, input logic ce);
    @(posedge clk);
    #1;
    driveInputs(name, idx, vs, hr, ce);
  endtask

  // Release reset: the two cycles after release still show drained zeros.
  task automatic releaseReset(input string name, input int idx);
    @(posedge clk);
    #1;
    sb.push_back(zero_exp(cyc + 1, "post_reset_zero1"));
    sb.push_back(zero_exp(cyc + 2, "post_reset_zero2"));
    rst_n = 1'b1;
    driveInputs(name, idx, 1'b0, 1'b1, 1'b1);
  endtask

  // Asynchronous reset in the middle of a cycle must clear outputs at once.
  task automatic assertResetMidCycle();
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    e = zero_exp(cyc, "async_reset_clear");
    checkOutput(e);
  endtask

  // Monitor: on each falling edge compare against zeros in reset, otherwise
  // against the queued entry due this cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput(zero_exp(cyc, "reset_state"));
    end else begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL missed_%s due=%0d now=%0d", sb[0].name, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        checkOutput(sb.pop_front());
      end
    end
  end

  // Safety net against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_Y  = 8'd0;
    per_img_Cb = 8'd0;
    per_img_Cr = 8'd0;

    repeat (3) @(posedge clk);
    releaseReset("grey_first", 0);

    // Directed conversions including clamps on several channels at once.
    applyStimulus("grey", 0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) begin
      applyStimulus($sformatf("vec%0d", i), i, 1'b0, 1'b1, 1'b1);
    end

    // Blanking data must be masked.
    applyStimulus("href_low_gate", 9, 1'b0, 1'b0, 1'b0);
    applyStimulus("href_low_gate2", 9, 1'b0, 1'b0, 1'b1);

    // Alternate href every cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus("href_toggle", 5, 1'b0, (i % 2 == 0), 1'b1);
    end

    // Qualifier alignment: vsync pulse, a 640-pixel line, toggling clken.
    for (int i = 0; i < 5; i++) begin
      applyStimulus("vsync_pulse", 0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus("vblank", 0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 640; i++) begin
      applyStimulus("line", i % NVEC, 1'b0, 1'b1, (i % 2 == 0));
    end
    applyStimulus("line_end", 2, 1'b0, 1'b0, 1'b0);
    applyStimulus("hblank", 2, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an active line.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("pre_reset", 6, 1'b0, 1'b1, 1'b1);
    end
    assertResetMidCycle();
    repeat (2) @(posedge clk);
    releaseReset("after_reset", 7);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("track", 8, 1'b0, 1'b1, 1'b1);
    end
    applyStimulus("idle", 0, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain got %0d pending want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
